// File: rtl/serial_sub32.sv
// Slice-serial subtractor: DIFF = A - B - bin, one SLICE-bit slice per clock, LSB first,
// computed as A + ~B + ~bin with the inter-slice carry held in a register.
module serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Handshake: start is accepted on a rising edge only when busy=0 (IDLE or DONE);
    // done is a one-cycle pulse and diff/bout/ovf stay valid until the next accept.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [SLICE:0]   slice_sum;
    logic             accept;
    logic             last_slice;

    assign accept     = start && (state_q != S_RUN);
    assign last_slice = (cnt_q == CW'(NSLICE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            nb_q   <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            nb_q   <= nb_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        a_d       = a_q;
        nb_d      = nb_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        slice_sum = {1'b0, a_q[cnt_q*SLICE +: SLICE]} + {1'b0, nb_q[cnt_q*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, c_q};
        if (accept) begin
            a_d    = A;
            nb_d   = ~B;
            c_d    = ~bin;
            cnt_d  = '0;
            diff_d = '0;
        end else if (state_q == S_RUN) begin
            diff_d[cnt_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            c_d = slice_sum[SLICE];
            if (!last_slice) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                // Carry out of A + ~B + ~bin is the inverted borrow; nb_q holds ~B.
                bout_d = ~slice_sum[SLICE];
                ovf_d  = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
endmodule
